mod997_digit_reducer: RTL and testbench

Sequential binary-to-residue reducer for the mod-997 datapath.
- Accepts one operand of up to 300 bits as a stream of 6-bit digits, MSB-first, over a valid/ready handshake.
- Accumulates by Horner's rule, acc = (acc*64 + digit) mod 997, one digit per cycle.
- Presents the 10-bit residue on a valid/ready output port.
- Sits between the operand source and the downstream mod-997 arithmetic. It serves as the streaming counterpart of the per-chunk residue tables.

---
 rtl/mod997_digit_reducer_pkg.sv | 29 ++
 rtl/mod997_digit_reducer_csub_chain.sv | 29 ++
 rtl/mod997_digit_reducer.sv | 108 ++++++++++
 tb/tb_mod997_digit_reducer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mod997_digit_reducer_pkg.sv
// mod997_pkg: shared constants and types for the mod-997 digit reducer.
//   MODULUS    : reduction modulus (997)
//   DIGIT_W    : bits per streamed operand digit
//   RES_W      : residue width
//   NUM_DIGITS : maximum digits per operand before truncation
//   ACC_W      : width of the pre-reduction value acc*64 + digit
//   CNT_W      : digit counter width
//   state_e    : reducer FSM states
//   mod_shift  : MODULUS << k, the subtrahend of reduction step k
package mod997_pkg;

    localparam int MODULUS    = 997;
    localparam int DIGIT_W    = 6;
    localparam int RES_W      = 10;
    localparam int NUM_DIGITS = 50;
    localparam int ACC_W      = 16;
    localparam int CNT_W      = 6;
    localparam int CSUB_STEPS = 6;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_e;

    function automatic logic [ACC_W-1:0] mod_shift(input int modulus, input int k);
        return ACC_W'(modulus << k);
    endfunction

endpackage

// File: rtl/mod997_digit_reducer_csub_chain.sv
// mod997_csub_chain: combinational reducer from an ACC_W-bit value to its
// residue modulo MODULUS, valid for inputs below MODULUS*2**CSUB_STEPS.
//   v_in    : input  ACC_W  value to reduce (at most 996*64+63)
//   res_out : output RES_W  v_in mod MODULUS
module mod997_csub_chain #(
    parameter int MODULUS = mod997_pkg::MODULUS,
    parameter int RES_W   = mod997_pkg::RES_W,
    parameter int ACC_W   = mod997_pkg::ACC_W
) (
    input  logic [ACC_W-1:0] v_in,
    output logic [RES_W-1:0] res_out
);
    import mod997_pkg::*;

    logic [ACC_W-1:0] v;

    // Binary long division by the modulus keeping only the remainder: each
    // step removes MODULUS<<k at most once, largest multiple first.
    always_comb begin
        v = v_in;
        for (int k = CSUB_STEPS - 1; k >= 0; k--) begin
            if (v >= mod_shift(MODULUS, k)) begin
                v = v - mod_shift(MODULUS, k);
            end
        end
        res_out = v[RES_W-1:0];
    end

endmodule

// File: rtl/mod997_digit_reducer.sv
// mod997_digit_reducer: streams an operand in MSB-first DIGIT_W-bit digits and
// returns its residue mod MODULUS using Horner's rule, one digit per cycle.
//   clk         : input  clock, rising edge
//   rst_n       : input  synchronous active-low reset
//   in_valid    : input  digit valid
//   in_ready    : output reducer can accept a digit
//   in_digit    : input  DIGIT_W operand digit, most significant first
//   in_last     : input  final digit of the operand
//   out_valid   : output residue valid
//   out_ready   : input  consumer accepts the residue
//   out_residue : output RES_W operand mod MODULUS
//   out_trunc   : output operand was cut at NUM_DIGITS without in_last
module mod997_digit_reducer #(
    parameter int MODULUS    = mod997_pkg::MODULUS,
    parameter int DIGIT_W    = mod997_pkg::DIGIT_W,
    parameter int RES_W      = mod997_pkg::RES_W,
    parameter int NUM_DIGITS = mod997_pkg::NUM_DIGITS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIGIT_W-1:0] in_digit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RES_W-1:0]   out_residue,
    output logic               out_trunc
);
    import mod997_pkg::*;

    state_e           state_q, state_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             trunc_q, trunc_d;

    logic [ACC_W-1:0] horner_v;
    logic [RES_W-1:0] horner_res;
    logic             accept;

    // acc*2**DIGIT_W + digit is just the concatenation of the two fields.
    assign horner_v = ACC_W'({acc_q, in_digit});

    mod997_csub_chain #(
        .MODULUS (MODULUS),
        .RES_W   (RES_W),
        .ACC_W   (ACC_W)
    ) u_csub (
        .v_in    (horner_v),
        .res_out (horner_res)
    );

    assign accept = (state_q == ACCUM) && in_valid;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        trunc_d = trunc_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = horner_res;
                    cnt_d = cnt_q + 1'b1;
                    if (in_last || (cnt_q == CNT_W'(NUM_DIGITS - 1))) begin
                        state_d = OUTPUT;
                        res_d   = horner_res;
                        trunc_d = !in_last;
                    end
                end
            end
            OUTPUT: begin
                // Accumulator is cleared on the handshake so the next frame
                // starts from zero; input stays blocked until the next cycle.
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            trunc_q <= trunc_d;
        end
    end

    assign in_ready    = (state_q == ACCUM);
    assign out_valid   = (state_q == OUTPUT);
    assign out_residue = res_q;
    assign out_trunc   = trunc_q;

endmodule

// File: tb/tb_mod997_digit_reducer.sv
// tb_mod997_digit_reducer: directed and randomized frames for the mod-997
// digit reducer, checked against a positional-weight residue model.
module tb_mod997_digit_reducer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_digit = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_residue;
    logic       out_trunc;

    int tests = 0;
    int fails = 0;
    int digs[$];
    int exp_res_g = 0;
    int exp_trunc_g = 0;

    mod997_digit_reducer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_digit    (in_digit),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_residue (out_residue),
        .out_trunc   (out_trunc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Operand value mod 997 as sum of digit * 64**position, each power
    // reduced independently.
    function automatic int ref_mod();
        longint p = 1;
        longint r = 0;
        for (int i = digs.size() - 1; i >= 0; i--) begin
            r = (r + longint'(digs[i]) * p) % 997;
            p = (p * 64) % 997;
        end
        return int'(r);
    endfunction

    // Plays digs[] into the DUT; the final digit carries in_last when
    // with_last is set. Checks the result one cycle after the final accept.
    task automatic play(input string tag, input bit with_last, input int exp_res,
                        input int exp_trunc);
        int guard;
        for (int i = 0; i < digs.size(); i++) begin
            in_valid = 1'b1;
            in_digit = 6'(digs[i]);
            in_last  = with_last && (i == digs.size() - 1);
            guard = 0;
            while (!in_ready && guard < 100) begin
                step();
                guard++;
            end
            chk({tag, "_in_ready"}, int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk({tag, "_out_valid"}, int'(out_valid), 1);
        chk({tag, "_residue"}, int'(out_residue), exp_res);
        chk({tag, "_trunc"}, int'(out_trunc), exp_trunc);
        exp_res_g   = exp_res;
        exp_trunc_g = exp_trunc;
    endtask

    // Holds out_ready low for 'hold' cycles, then completes the handshake.
    task automatic drain(input string tag, input int hold);
        out_ready = 1'b0;
        repeat (hold) begin
            step();
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_res"}, int'(out_residue), exp_res_g);
            chk({tag, "_hold_trunc"}, int'(out_trunc), exp_trunc_g);
            chk({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, int'(out_valid), 0);
        chk({tag, "_post_in_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        longint p2;
        int     golden;
        int     n;
        bit     wl;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_residue", int'(out_residue), 0);
        chk("rst_trunc", int'(out_trunc), 0);

        // Single-digit frame
        digs = '{63};
        play("single63", 1'b1, 63, 0);
        drain("single63", 0);

        digs = '{1, 0};
        play("d1_0", 1'b1, 64, 0);
        drain("d1_0", 1);

        digs = '{15, 37};
        play("d15_37", 1'b1, 0, 0);
        drain("d15_37", 0);

        digs = '{63, 63};
        play("d63_63", 1'b1, 107, 0);
        drain("d63_63", 0);

        // 50 digits of 63 = 2**300-1, last on the 50th position
        p2 = 1;
        repeat (300) p2 = (p2 * 2) % 997;
        golden = int'((p2 + 996) % 997);
        digs.delete();
        repeat (50) digs.push_back(63);
        play("all_ones", 1'b1, golden, 0);
        drain("all_ones", 0);

        // Truncation at the 50th digit without in_last
        digs.delete();
        repeat (49) digs.push_back(0);
        digs.push_back(5);
        play("trunc", 1'b0, 5, 1);
        drain("trunc", 0);

        digs = '{7};
        play("after_trunc", 1'b1, 7, 0);
        drain("after_trunc", 0);

        // Backpressure with a pending input digit that must not be consumed
        digs = '{3, 4};
        play("bp", 1'b1, 196, 0);
        in_valid = 1'b1;
        in_digit = 6'd11;
        in_last  = 1'b1;
        drain("bp", 5);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_next_valid", int'(out_valid), 1);
        chk("bp_next_res", int'(out_residue), 11);
        drain("bp_next", 0);

        // Reset mid-frame
        digs = '{9, 9, 9};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_digit = 6'd9;
            step();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_in_ready", int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        digs = '{2};
        play("midrst_frame", 1'b1, 2, 0);

        // Reset while an output is pending
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("outrst_out_valid", int'(out_valid), 0);
        chk("outrst_in_ready", int'(in_ready), 1);
        chk("outrst_residue", int'(out_residue), 0);

        // Randomized frames against the reference model
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 50);
            digs.delete();
            for (int i = 0; i < n; i++) digs.push_back(int'($urandom_range(0, 63)));
            wl = (n < 50) ? 1'b1 : 1'(($urandom_range(0, 1)));
            play($sformatf("rnd%0d", f), wl, ref_mod(), wl ? 0 : 1);
            drain($sformatf("rnd%0d", f), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
